// File: rtl/peripheral_ahb3_pkg.sv
// Shared AHB3-Lite definitions: transfer type, size, burst and response
// encodings, plus the data-phase state of the single-port RAM slave.
// The ERR1/ERR2 states only exist when PERIPHERAL_SPRAM_AHB3_ERR_EN is defined.
package peripheral_ahb3_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'b000,
        HSIZE_HWORD = 3'b001,
        HSIZE_WORD  = 3'b010,
        HSIZE_DWORD = 3'b011,
        HSIZE_B128  = 3'b100,
        HSIZE_B256  = 3'b101,
        HSIZE_B512  = 3'b110,
        HSIZE_B1024 = 3'b111
    } hsize_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_t;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_t;

    // Data-phase state of the SRAM slave
`ifdef PERIPHERAL_SPRAM_AHB3_ERR_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RWAIT = 2'b01,
        ST_ERR1  = 2'b10,
        ST_ERR2  = 2'b11
    } spram_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RWAIT = 2'b01
    } spram_state_t;
`endif

endpackage

// File: rtl/peripheral_spram_ahb3_ws_if.sv
// AHB3-Lite slave port bundle for the single-port RAM peripheral.
interface peripheral_spram_ahb3_ws_if #(
    parameter int PLEN = 32,
    parameter int XLEN = 32
);
    logic            HSEL;
    logic [PLEN-1:0] HADDR;
    logic [XLEN-1:0] HWDATA;
    logic            HWRITE;
    logic [2:0]      HSIZE;
    logic [2:0]      HBURST;
    logic [3:0]      HPROT;
    logic [1:0]      HTRANS;
    logic            HMASTLOCK;
    logic            HREADY;
    logic [XLEN-1:0] HRDATA;
    logic            HREADYOUT;
    logic            HRESP;

    modport master (
        output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS,
               HMASTLOCK, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS,
               HMASTLOCK, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/peripheral_spram_1r1w.sv
// One-read/one-write RAM with byte-enabled writes and a registered read port.
// A read and write to the same word in one cycle returns the old contents.
module peripheral_spram_1r1w #(
    parameter int ABITS      = 8,
    parameter int DBITS      = 32,
    parameter     TECHNOLOGY = "GENERIC"
) (
    input  logic               clk,
    input  logic [ABITS-1:0]   waddr,
    input  logic               we,
    input  logic [DBITS/8-1:0] be,
    input  logic [DBITS-1:0]   din,
    input  logic [ABITS-1:0]   raddr,
    input  logic               re,
    output logic [DBITS-1:0]   dout
);
    logic [DBITS-1:0] mem [2**ABITS];

    // Vendor macros would be selected here; every target maps onto the
    // behavioural array below until one is characterised.
    if (TECHNOLOGY != "GENERIC") begin : g_tech_fallback
    end

    // Byte-lane write and registered read of the storage array
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < DBITS/8; i++) begin
                if (be[i]) mem[waddr][i*8 +: 8] <= din[i*8 +: 8];
            end
        end
        if (re) dout <= mem[raddr];
    end
endmodule

// File: rtl/peripheral_spram_ahb3_ws.sv
// AHB3-Lite single-port RAM slave with configurable read wait states.
// Writes are zero-wait; a read that hits the write still in its data phase
// gets the new bytes forwarded. Define PERIPHERAL_SPRAM_AHB3_ERR_EN to return
// a two-cycle ERROR for out-of-range addresses or oversized transfers;
// otherwise addresses wrap modulo MEM_DEPTH and HRESP is always OKAY.
module peripheral_spram_ahb3_ws
    import peripheral_ahb3_pkg::*;
#(
    parameter int MEM_DEPTH   = 256,
    parameter int PLEN        = 32,
    parameter int XLEN        = 32,
    parameter int WAIT_STATES = 0,
    parameter     TECHNOLOGY  = "GENERIC"
) (
    input logic                       HCLK,
    input logic                       HRESETn,
    peripheral_spram_ahb3_ws_if.slave ahb
);
    localparam int          BE_W  = XLEN / 8;
    localparam int          BO    = $clog2(BE_W);
    localparam int          BOW   = (BO > 0) ? BO : 1;
    localparam int          ABITS = $clog2(MEM_DEPTH);
    localparam logic [2:0]  WS    = 3'(WAIT_STATES);

    // HSIZE lane mask moved onto the addressed byte lanes
    function automatic logic [BE_W-1:0] gen_be(input logic [2:0] size,
                                               input logic [PLEN-1:0] addr);
        logic [BE_W-1:0] mask;
        int unsigned     off;
        mask = '0;
        for (int i = 0; i < BE_W; i++) begin
            if (i < (1 << size)) mask[i] = 1'b1;
        end
        off = 32'(addr[BOW-1:0]) & 32'(BE_W - 1);
        return mask << off;
    endfunction

    spram_state_t     state_q;
    logic [2:0]       cnt_q;
    logic             ready_q;
    logic             accept, acc_err, acc_wr, acc_rd, rd_done, mem_we;
    logic [ABITS-1:0] haddr_word;
    logic [BE_W-1:0]  hbe;
    logic             wr_p1, rd_p1;
    logic [ABITS-1:0] waddr_p1;
    logic [BE_W-1:0]  be_p1, fwd_be_p1;
    logic [XLEN-1:0]  fwd_data_p1, mem_dout, rd_word, rdata_q;
    logic             unused_sig;

    assign accept     = ahb.HSEL & ahb.HREADY &
                        ((ahb.HTRANS == HTRANS_NONSEQ) | (ahb.HTRANS == HTRANS_SEQ));
    assign haddr_word = ahb.HADDR[BO +: ABITS];
    assign hbe        = gen_be(ahb.HSIZE, ahb.HADDR);

`ifdef PERIPHERAL_SPRAM_AHB3_ERR_EN
    localparam int              LW    = PLEN + 1;
    localparam logic [PLEN:0]   LIMIT = LW'(MEM_DEPTH * BE_W);
    logic resp_q;
    assign acc_err  = accept & (({1'b0, ahb.HADDR} >= LIMIT) | (int'(ahb.HSIZE) > BO));
    assign ahb.HRESP = resp_q;
`else
    assign acc_err  = 1'b0;
    assign ahb.HRESP = HRESP_OKAY;
`endif

    assign acc_wr = accept & ahb.HWRITE & ~acc_err;
    assign acc_rd = accept & ~ahb.HWRITE & ~acc_err;

    // Data-phase FSM: wait-state countdown, error sequencing, HREADYOUT/HRESP
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            ready_q <= 1'b1;
`ifdef PERIPHERAL_SPRAM_AHB3_ERR_EN
            resp_q  <= HRESP_OKAY;
`endif
        end else if (state_q == ST_RWAIT && cnt_q != 3'd0) begin
            cnt_q   <= cnt_q - 3'd1;
            ready_q <= (cnt_q == 3'd1);
        end
`ifdef PERIPHERAL_SPRAM_AHB3_ERR_EN
        else if (state_q == ST_ERR1) begin
            state_q <= ST_ERR2;
            ready_q <= 1'b1;
        end
`endif
        else begin
`ifdef PERIPHERAL_SPRAM_AHB3_ERR_EN
            resp_q <= acc_err ? HRESP_ERROR : HRESP_OKAY;
            if (acc_err) begin
                state_q <= ST_ERR1;
                ready_q <= 1'b0;
            end else
`endif
            if (acc_rd && WS != 3'd0) begin
                state_q <= ST_RWAIT;
                cnt_q   <= WS;
                ready_q <= 1'b0;
            end else begin
                state_q <= ST_IDLE;
                ready_q <= 1'b1;
            end
        end
    end

    // Address phase -> data phase: which transfer is pending and whether forwarding applies
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_p1     <= 1'b0;
            rd_p1     <= 1'b0;
            fwd_be_p1 <= '0;
        end else if (ahb.HREADY) begin
            wr_p1     <= acc_wr;
            rd_p1     <= acc_rd;
            fwd_be_p1 <= (acc_rd && wr_p1 && waddr_p1 == haddr_word) ? be_p1 : '0;
        end
    end

    // Address phase -> data phase: write target and forwarded write data
    always_ff @(posedge HCLK) begin
        if (ahb.HREADY) begin
            if (acc_wr) begin
                waddr_p1 <= haddr_word;
                be_p1    <= hbe;
            end
            if (acc_rd && wr_p1) fwd_data_p1 <= ahb.HWDATA;
        end
    end

    assign mem_we = wr_p1 & ahb.HREADY;

    peripheral_spram_1r1w #(
        .ABITS      (ABITS),
        .DBITS      (XLEN),
        .TECHNOLOGY (TECHNOLOGY)
    ) u_mem (
        .clk   (HCLK),
        .waddr (waddr_p1),
        .we    (mem_we),
        .be    (be_p1),
        .din   (ahb.HWDATA),
        .raddr (haddr_word),
        .re    (acc_rd),
        .dout  (mem_dout)
    );

    // Merge forwarded write bytes over the word read from the array
    always_comb begin
        rd_word = mem_dout;
        for (int i = 0; i < BE_W; i++) begin
            if (fwd_be_p1[i]) rd_word[i*8 +: 8] = fwd_data_p1[i*8 +: 8];
        end
    end

    assign rd_done = rd_p1 & ready_q;

    // Keep the last completed read so HRDATA holds between reads
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)     rdata_q <= '0;
        else if (rd_done) rdata_q <= rd_word;
    end

    assign ahb.HRDATA    = rd_done ? rd_word : rdata_q;
    assign ahb.HREADYOUT = ready_q;

    assign unused_sig = ^{ahb.HBURST, ahb.HPROT, ahb.HMASTLOCK, ahb.HADDR};
endmodule

// File: tb/tb_peripheral_spram_ahb3_ws.sv
// Directed bench for peripheral_spram_ahb3_ws: three slaves with 0, 1 and 2
// read wait states share one stimulus bus, selected one at a time.
module tb_peripheral_spram_ahb3_ws;
    import peripheral_ahb3_pkg::*;

    logic        HCLK;
    logic        HRESETn;
    logic        hsel, hwrite;
    logic [31:0] haddr, hwdata;
    logic [2:0]  hsize, hburst;
    logic [1:0]  htrans;
    logic [1:0]  sel;
    logic [2:0]  ready_a, resp_a;
    logic [2:0][31:0] rdata_a;
    logic        rdy, rsp;
    logic [31:0] rdat;
    int          n_checks = 0;
    int          n_errors = 0;

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        peripheral_spram_ahb3_ws_if #(.PLEN(32), .XLEN(32)) bus ();
        assign bus.HSEL      = hsel && (sel == 2'(g));
        assign bus.HADDR     = haddr;
        assign bus.HWDATA    = hwdata;
        assign bus.HWRITE    = hwrite;
        assign bus.HSIZE     = hsize;
        assign bus.HBURST    = hburst;
        assign bus.HPROT     = 4'b0011;
        assign bus.HTRANS    = htrans;
        assign bus.HMASTLOCK = 1'b0;
        assign bus.HREADY    = bus.HREADYOUT;
        assign ready_a[g]    = bus.HREADYOUT;
        assign resp_a[g]     = bus.HRESP;
        assign rdata_a[g]    = bus.HRDATA;

        peripheral_spram_ahb3_ws #(
            .MEM_DEPTH   (256),
            .PLEN        (32),
            .XLEN        (32),
            .WAIT_STATES (g),
            .TECHNOLOGY  ("GENERIC")
        ) u_dut (
            .HCLK    (HCLK),
            .HRESETn (HRESETn),
            .ahb     (bus)
        );
    end

    assign rdy  = ready_a[sel];
    assign rsp  = resp_a[sel];
    assign rdat = rdata_a[sel];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic go_idle();
        hsel   = 1'b0;
        htrans = HTRANS_IDLE;
        hwrite = 1'b0;
    endtask

    task automatic ahb_write(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data);
        hsel = 1'b1; htrans = HTRANS_NONSEQ; hburst = HBURST_SINGLE;
        hwrite = 1'b1; haddr = addr; hsize = size;
        cyc();
        go_idle();
        hwdata = data;
        check("wr_ready", 32'(rdy), 32'd1);
        cyc();
    endtask

    // n-beat read; addrs/exp indexed by beat number, every beat must show exp_ws waits
    task automatic ahb_read(input string tag, input int n, input logic [3:0][31:0] addrs,
                            input logic [3:0][31:0] exp, input int exp_ws, input logic [2:0] burst);
        int waits;
        hsel = 1'b1; hwrite = 1'b0; hsize = HSIZE_WORD; hburst = burst;
        htrans = HTRANS_NONSEQ; haddr = addrs[0];
        cyc();
        for (int b = 0; b < n; b++) begin
            if (b < n - 1) begin
                haddr  = addrs[b+1];
                htrans = HTRANS_SEQ;
            end else begin
                go_idle();
            end
            waits = 0;
            while (rdy == 1'b0 && waits < 20) begin
                cyc();
                waits++;
            end
            check({tag, "_ws"}, 32'(waits), 32'(exp_ws));
            check({tag, "_data"}, rdat, exp[b]);
            cyc();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        HRESETn = 1'b0; sel = 2'd0; hwdata = '0; haddr = '0;
        hsize = HSIZE_WORD; hburst = HBURST_SINGLE;
        go_idle();
        repeat (2) cyc();
        for (int g = 0; g < 3; g++) begin
            sel = 2'(g);
            #1;
            check("rst_ready", 32'(rdy), 32'd1);
            check("rst_resp", 32'(rsp), 32'd0);
            check("rst_rdata", rdat, 32'd0);
        end
        #3 HRESETn = 1'b1;
        cyc();

        // zero wait states: write then read, then hold, then IDLE/BUSY
        sel = 2'd0;
        ahb_write(32'h10, HSIZE_WORD, 32'hDEADBEEF);
        ahb_read("r_ws0", 1, {96'd0, 32'h10}, {96'd0, 32'hDEADBEEF}, 0, HBURST_SINGLE);
        repeat (3) cyc();
        check("rdata_hold", rdat, 32'hDEADBEEF);
        hsel = 1'b1; htrans = HTRANS_BUSY;
        cyc();
        check("busy_ready", 32'(rdy), 32'd1);
        check("busy_resp", 32'(rsp), 32'd0);
        go_idle();
        cyc();
        check("busy_rdata", rdat, 32'hDEADBEEF);

        // byte write @0x12 directly followed by word read @0x10
        hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b1; haddr = 32'h12; hsize = HSIZE_BYTE;
        cyc();
        hwdata = 32'h0055_0000; hwrite = 1'b0; haddr = 32'h10; hsize = HSIZE_WORD;
        check("fwd_wr_ready", 32'(rdy), 32'd1);
        cyc();
        go_idle();
        check("fwd_rd_ready", 32'(rdy), 32'd1);
        check("fwd_rd_data", rdat, 32'hDE55BEEF);
        cyc();
        ahb_read("r_after_fwd", 1, {96'd0, 32'h10}, {96'd0, 32'hDE55BEEF}, 0, HBURST_SINGLE);

        // reset across a write data phase suppresses the write
        ahb_write(32'h20, HSIZE_WORD, 32'h11111111);
        hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b1; haddr = 32'h20; hsize = HSIZE_WORD;
        cyc();
        go_idle();
        hwdata = 32'h22222222;
        #2 HRESETn = 1'b0;
        cyc();
        #3 HRESETn = 1'b1;
        cyc();
        ahb_read("r_rst_wr", 1, {96'd0, 32'h20}, {96'd0, 32'h11111111}, 0, HBURST_SINGLE);

`ifdef PERIPHERAL_SPRAM_AHB3_ERR_EN
        ahb_write(32'h0, HSIZE_WORD, 32'hA5A5A5A5);
        hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b1; haddr = 32'h400; hsize = HSIZE_WORD;
        cyc();
        go_idle();
        hwdata = 32'h12345678;
        check("err1_ready", 32'(rdy), 32'd0);
        check("err1_resp", 32'(rsp), 32'd1);
        cyc();
        check("err2_ready", 32'(rdy), 32'd1);
        check("err2_resp", 32'(rsp), 32'd1);
        cyc();
        check("err_done_resp", 32'(rsp), 32'd0);
        ahb_read("r_err_rb", 1, {96'd0, 32'h0}, {96'd0, 32'hA5A5A5A5}, 0, HBURST_SINGLE);
`else
        ahb_write(32'h400, HSIZE_WORD, 32'h12345678);
        check("wrap_resp", 32'(rsp), 32'd0);
        ahb_read("r_wrap_rb", 1, {96'd0, 32'h0}, {96'd0, 32'h12345678}, 0, HBURST_SINGLE);
`endif

        // two wait states, then reset while the read is stalled
        sel = 2'd2;
        ahb_write(32'h10, HSIZE_WORD, 32'hDEADBEEF);
        ahb_read("r_ws2", 1, {96'd0, 32'h10}, {96'd0, 32'hDEADBEEF}, 2, HBURST_SINGLE);
        hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b0; haddr = 32'h10; hsize = HSIZE_WORD;
        cyc();
        go_idle();
        check("rwait_ready", 32'(rdy), 32'd0);
        check("rwait_hold", rdat, 32'hDEADBEEF);
        #2 HRESETn = 1'b0;
        #1;
        check("rwait_rst_ready", 32'(rdy), 32'd1);
        check("rwait_rst_rdata", rdat, 32'd0);
        #3 HRESETn = 1'b1;
        cyc();
        ahb_read("r_after_rst", 1, {96'd0, 32'h10}, {96'd0, 32'hDEADBEEF}, 2, HBURST_SINGLE);

        // WRAP4 read burst from 0x0C, one wait state per beat
        sel = 2'd1;
        ahb_write(32'h00, HSIZE_WORD, 32'h11110000);
        ahb_write(32'h04, HSIZE_WORD, 32'h22224444);
        ahb_write(32'h08, HSIZE_WORD, 32'h33338888);
        ahb_write(32'h0C, HSIZE_WORD, 32'h4444CCCC);
        ahb_read("r_wrap4", 4,
                 {32'h08, 32'h04, 32'h00, 32'h0C},
                 {32'h33338888, 32'h22224444, 32'h11110000, 32'h4444CCCC},
                 1, HBURST_WRAP4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/peripheral_spram_ahb3_ws.md
PERIPHERAL_SPRAM_AHB3_WS -- requirements
Module: peripheral_spram_ahb3_ws

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256, meaning number of XLEN-wide words.
REQ-002 SHALL have parameter PLEN, default 32, meaning HADDR width.
REQ-003 SHALL have parameter XLEN, default 32, meaning data width (8..1024, power of 2).
REQ-004 SHALL have parameter WAIT_STATES, default 0, meaning read data-phase wait states (0..7).
REQ-005 SHALL have parameter TECHNOLOGY, default "GENERIC", meaning memory macro selector passed to the memory sub-module.
REQ-006 SHALL have port HCLK, input, 1 bit, clock; reset HRESETn, asynchronous, active-low.
REQ-007 SHALL have port HRESETn, input, 1 bit, asynchronous active-low reset.
REQ-008 SHALL have inputs HSEL 1, HADDR PLEN, HWDATA XLEN, HWRITE 1, HSIZE 3, HBURST 3, HPROT 4, HTRANS 2, HMASTLOCK 1, HREADY 1, with AHB3-Lite slave meaning.
REQ-009 SHALL have outputs HRDATA XLEN, HREADYOUT 1, HRESP 1, with AHB3-Lite slave meaning.

Function
REQ-010 SHALL accept a transfer only when HSEL & HREADY & HTRANS is NONSEQ or SEQ; IDLE/BUSY get a zero-wait OKAY.
REQ-011 SHALL run a data-phase FSM with states IDLE, RWAIT, ERR1, ERR2.
REQ-012 Writes SHALL complete with zero wait states: address/byte-enables registered in the address phase, memory written in the data phase with HWDATA.
REQ-013 Byte-enables SHALL equal the HSIZE lane mask shifted by HADDR[log2(XLEN/8)-1:0].
REQ-014 Reads with WAIT_STATES=0 SHALL return HRDATA in the first data-phase cycle with HREADYOUT=1.
REQ-015 Reads with WAIT_STATES=N>0 SHALL go IDLE->RWAIT, hold HREADYOUT=0 for exactly N cycles via a down-counter, then drive HREADYOUT=1 with valid HRDATA and return to IDLE or accept the next pipelined transfer.
REQ-016 A read whose word address equals the pending write's word address SHALL return forwarded data: written bytes from HWDATA, remaining bytes from memory, with no stall.
REQ-017 Back-to-back SEQ bursts (INCR, WRAP4/8/16) SHALL be handled as independent transfers; each read burst beat incurs WAIT_STATES.
REQ-018 HRDATA SHALL hold its last value when no read completes.
REQ-019 Deasserting HSEL during RWAIT SHALL NOT abort the outstanding read.

Reset
REQ-020 During HRESETn=0: HREADYOUT=1, HRESP=OKAY, HRDATA=0, FSM=IDLE, wait counter=0, pending write cleared.
REQ-021 Reset asserted mid-write SHALL suppress the memory write; memory contents are not cleared.

Configuration
REQ-022 Macro PERIPHERAL_SPRAM_AHB3_ERR_EN SHALL enable error checking: a transfer with byte address >= MEM_DEPTH*XLEN/8, or HSIZE wider than XLEN, goes IDLE->ERR1 (HREADYOUT=0, HRESP=ERROR) -> ERR2 (HREADYOUT=1, HRESP=ERROR) -> IDLE, with the write suppressed and HRDATA unchanged.
REQ-023 Without PERIPHERAL_SPRAM_AHB3_ERR_EN, ERR1/ERR2 SHALL not exist, HRESP SHALL be tied OKAY, and addresses SHALL wrap modulo MEM_DEPTH words.

Structure
REQ-024 HTRANS/HSIZE/HBURST/HRESP constants SHALL come from the shared peripheral_ahb3_pkg; the FSM state enum SHALL be added to that package.
REQ-025 Storage SHALL be one instance of the existing sub-module peripheral_spram_1r1w (ABITS=$clog2(MEM_DEPTH), DBITS=XLEN).

Verification (XLEN=32, MEM_DEPTH=256)
REQ-026 WAIT_STATES=0: write word 0xDEADBEEF @0x10, read @0x10 -> HRDATA=0xDEADBEEF, HREADYOUT never low.
REQ-027 WAIT_STATES=2: read @0x10 -> HREADYOUT low exactly 2 cycles, then 0xDEADBEEF with HREADYOUT=1.
REQ-028 Byte write 0x55 @0x12 immediately followed by word read @0x10 -> HRDATA=0xDE55BEEF in the same data phase, no stall.
REQ-029 ERR_EN defined: write @0x400 -> two-cycle ERROR (ERR1 HREADYOUT=0, ERR2 HREADYOUT=1); word @0x000 unchanged on readback. Undefined: write 0x12345678 @0x400 -> OKAY, readback @0x000 = 0x12345678.
REQ-030 WRAP4 read burst from 0x0C with WAIT_STATES=1 -> addresses 0x0C,0x00,0x04,0x08, each beat one wait state, data correct.
REQ-031 HRESETn pulsed low during RWAIT -> HREADYOUT=1, HRDATA=0 immediately; the next read completes normally.
